// File: rtl/gty_quad_reset_sequencer.sv
// gty_quad_reset_sequencer: power-good settle, reset_all pulse, userclk gating and run-time
// supervision for one GTY quad; restarts the sequence on power loss, reset-done loss or timeout.
//
// Ports:
//   clk              free-running clock (same as gtwiz_reset_clk_freerun_in)
//   rst              synchronous active-high reset
//   pwrgood          per-lane gtpowergood_out (async)
//   tx_pmaresetdone  per-lane TX PMA reset done (async)
//   rx_pmaresetdone  per-lane RX PMA reset done (async)
//   tx_done, rx_done gtwiz_reset_tx/rx_done_out (async)
//   link_up          per-lane PCS link state (async)
//   gty_reset        to gtwiz_reset_all_in
//   tx_clock_stable  to gtwiz_userclk_tx_active_in
//   rx_clock_stable  to gtwiz_userclk_rx_active_in
//   quad_ready       high only while the quad is running
//   seq_state        current sequencer state (debug)
//   retry_count      saturating count of sequence restarts since rst
//   timeout_err      sticky flag for any PMA/DONE/LINK timeout
module gty_quad_reset_sequencer #(
    parameter int LANES         = 4,
    parameter int SETTLE_CYCLES = 65536,
    parameter int RESET_CYCLES  = 128,
    parameter int PMA_TIMEOUT   = 125000,
    parameter int DONE_TIMEOUT  = 1250000,
    parameter int LINK_TIMEOUT  = 12500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] pwrgood,
    input  logic [LANES-1:0] tx_pmaresetdone,
    input  logic [LANES-1:0] rx_pmaresetdone,
    input  logic             tx_done,
    input  logic             rx_done,
    input  logic [LANES-1:0] link_up,
    output logic             gty_reset,
    output logic             tx_clock_stable,
    output logic             rx_clock_stable,
    output logic             quad_ready,
    output logic [2:0]       seq_state,
    output logic [7:0]       retry_count,
    output logic             timeout_err
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXP = max2(max2(SETTLE_CYCLES, RESET_CYCLES),
                               max2(max2(PMA_TIMEOUT, DONE_TIMEOUT), LINK_TIMEOUT));
    localparam int CW   = $clog2(MAXP) + 1;
    localparam int SW   = 4 * LANES + 2;

    localparam logic [CW-1:0] LD_SETTLE = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] LD_RESET  = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] LD_PMA    = CW'(PMA_TIMEOUT - 1);
    localparam logic [CW-1:0] LD_DONE   = CW'(DONE_TIMEOUT - 1);
    localparam logic [CW-1:0] LD_LINK   = CW'((LINK_TIMEOUT > 0) ? LINK_TIMEOUT - 1 : 0);
    localparam logic          LINK_EN   = (LINK_TIMEOUT != 0);

    typedef enum logic [2:0] {
        WAIT_PGOOD = 3'd0,
        SETTLE     = 3'd1,
        RESET      = 3'd2,
        WAIT_PMA   = 3'd3,
        WAIT_DONE  = 3'd4,
        RUN        = 3'd5
    } state_t;

    logic [SW-1:0]    sync1;
    logic [SW-1:0]    sync2;
    logic [LANES-1:0] pg_s;
    logic [LANES-1:0] txp_s;
    logic [LANES-1:0] rxp_s;
    logic [LANES-1:0] link_s;
    logic             txd_s;
    logic             rxd_s;
    logic             pg_all;

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic             tx_n;
    logic             rx_n;
    logic [7:0]       retry_n;
    logic             terr_n;
    logic             restart;
    logic             tout;

    // All async status bundled through one 2-FF synchronizer.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {link_up, rx_pmaresetdone, tx_pmaresetdone, pwrgood, rx_done, tx_done};
            sync2 <= sync1;
        end
    end

    assign {link_s, rxp_s, txp_s, pg_s, rxd_s, txd_s} = sync2;
    assign pg_all = &pg_s;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tx_n    = tx_clock_stable;
        rx_n    = rx_clock_stable;
        retry_n = retry_count;
        terr_n  = timeout_err;
        restart = 1'b0;
        tout    = 1'b0;

        unique case (state)
            WAIT_PGOOD: begin
                if (pg_all) begin
                    state_n = SETTLE;
                    cnt_n   = LD_SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_n = RESET;
                    cnt_n   = LD_RESET;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            RESET: begin
                tx_n = 1'b0;
                rx_n = 1'b0;
                if (cnt == '0) begin
                    state_n = WAIT_PMA;
                    cnt_n   = LD_PMA;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            WAIT_PMA: begin
                if (&txp_s) tx_n = 1'b1;
                if (&rxp_s) rx_n = 1'b1;
                if (tx_n && rx_n) begin
                    state_n = WAIT_DONE;
                    cnt_n   = LD_DONE;
                end else if (cnt == '0) begin
                    restart = 1'b1;
                    tout    = 1'b1;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            WAIT_DONE: begin
                if (txd_s && rxd_s) begin
                    state_n = RUN;
                    cnt_n   = LD_LINK;
                end else if (cnt == '0) begin
                    restart = 1'b1;
                    tout    = 1'b1;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            RUN: begin
                // Zero count is terminal: a link seen on the expiry cycle does not rescue it.
                tout = LINK_EN && (cnt == '0);
                if (!(txd_s && rxd_s) || tout) begin
                    restart = 1'b1;
                end else if (|link_s) begin
                    cnt_n = LD_LINK;
                end else if (LINK_EN) begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = WAIT_PGOOD;
                cnt_n   = '0;
            end
        endcase

        if (restart) begin
            state_n = RESET;
            cnt_n   = LD_RESET;
            tx_n    = 1'b0;
            rx_n    = 1'b0;
            if (retry_count != 8'hFF) retry_n = retry_count + 8'd1;
        end
        if (tout) terr_n = 1'b1;

        // Power loss overrides everything, including a simultaneous timeout.
        if (state != WAIT_PGOOD && !pg_all) begin
            state_n = WAIT_PGOOD;
            cnt_n   = '0;
            tx_n    = 1'b0;
            rx_n    = 1'b0;
            retry_n = retry_count;
            terr_n  = timeout_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= WAIT_PGOOD;
            cnt             <= '0;
            tx_clock_stable <= 1'b0;
            rx_clock_stable <= 1'b0;
            retry_count     <= '0;
            timeout_err     <= 1'b0;
            gty_reset       <= 1'b0;
            quad_ready      <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            tx_clock_stable <= tx_n;
            rx_clock_stable <= rx_n;
            retry_count     <= retry_n;
            timeout_err     <= terr_n;
            gty_reset       <= (state_n == RESET);
            quad_ready      <= (state_n == RUN);
        end
    end

    assign seq_state = state;

endmodule
